// File: rtl/sub32_serial.sv
// Digit-serial subtractor: diff = a - b - bin, DIGIT bits per clock, LSB digit first.
// Optional signed-overflow output is enabled with the SUB32_OVF_EN macro.
//
// state  | meaning
// IDLE   | waiting for operands, in_ready=1
// RUN    | one digit per cycle, then one cycle to latch bout/ovf
// DONE   | result held, out_valid=1 until out_ready
module sub32_serial #(
  parameter int WIDTH = 32,
  parameter int DIGIT = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] diff,
  output logic             bout
`ifdef SUB32_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int NDIG = WIDTH / DIGIT;
  localparam int CW = $clog2(NDIG + 1);
  localparam logic [CW-1:0] LAST = CW'(NDIG);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_t;

  state_t           state_q, state_d;
  logic             accept, finish;
  logic [WIDTH-1:0] a_q, b_q;
  logic             borrow_q;
  logic [CW-1:0]    cnt_q;
  logic [DIGIT:0]   dig_res;
  logic [WIDTH+DIGIT-1:0] diff_cat;

  always_comb begin
    state_d   = state_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    accept    = 1'b0;
    finish    = 1'b0;
    case (state_q)
      S_IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          accept  = 1'b1;
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        // Counter reaching NDIG means every digit is in diff; spend this cycle latching.
        if (cnt_q == LAST) begin
          finish  = 1'b1;
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign dig_res  = {1'b0, a_q[DIGIT-1:0]} - {1'b0, b_q[DIGIT-1:0]} - {{DIGIT{1'b0}}, borrow_q};
  assign diff_cat = {dig_res[DIGIT-1:0], diff};

`ifdef SUB32_OVF_EN
  logic a_msb_q, b_msb_q;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      a_q      <= '0;
      b_q      <= '0;
      borrow_q <= 1'b0;
      cnt_q    <= '0;
      diff     <= '0;
      bout     <= 1'b0;
`ifdef SUB32_OVF_EN
      a_msb_q  <= 1'b0;
      b_msb_q  <= 1'b0;
      ovf      <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      if (accept) begin
        a_q      <= a;
        b_q      <= b;
        borrow_q <= bin;
        cnt_q    <= '0;
        diff     <= '0;
        bout     <= 1'b0;
`ifdef SUB32_OVF_EN
        a_msb_q  <= a[WIDTH-1];
        b_msb_q  <= b[WIDTH-1];
        ovf      <= 1'b0;
`endif
      end else if (finish) begin
        bout <= borrow_q;
`ifdef SUB32_OVF_EN
        ovf  <= (a_msb_q != b_msb_q) & (diff[WIDTH-1] != a_msb_q);
`endif
      end else if (state_q == S_RUN) begin
        // Operands shift down so the active digit is always at bit 0.
        diff     <= diff_cat[WIDTH+DIGIT-1:DIGIT];
        a_q      <= a_q >> DIGIT;
        b_q      <= b_q >> DIGIT;
        borrow_q <= dig_res[DIGIT];
        cnt_q    <= cnt_q + CW'(1);
      end
    end
  end

endmodule

// File: tb/tb_sub32_serial.sv
// Self-checking bench for sub32_serial: scoreboard of expected results, one task per scenario.
module tb_sub32_serial;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] a, b;
  logic        bin;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] diff;
  logic        bout;
`ifdef SUB32_OVF_EN
  logic        ovf;
`endif

  int n_checks = 0;
  int n_fail = 0;

  typedef struct {
    logic [31:0] d;
    logic        bo;
    logic        ov;
  } exp_t;

  typedef struct {
    logic [31:0] va;
    logic [31:0] vb;
    logic        vbin;
  } vec_t;

  exp_t sb[$];

  always #5 clk = ~clk;

  sub32_serial #(.WIDTH(32), .DIGIT(4)) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .a        (a),
    .b        (b),
    .bin      (bin),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .diff     (diff),
    .bout     (bout)
`ifdef SUB32_OVF_EN
    ,
    .ovf      (ovf)
`endif
  );

  function automatic exp_t model(input logic [31:0] ma, input logic [31:0] mb, input logic mbin);
    exp_t e;
    logic [32:0] t;
    t    = {1'b0, ma} - {1'b0, mb} - {32'b0, mbin};
    e.d  = t[31:0];
    e.bo = t[32];
    e.ov = (ma[31] != mb[31]) && (t[31] != ma[31]);
    return e;
  endfunction

  // Drive one request, push its expected result once accepted, then scramble the inputs.
  task automatic start_op(input logic [31:0] ai, input logic [31:0] bi, input logic bini,
                          output bit ok);
    int k;
    a = ai; b = bi; bin = bini; in_valid = 1'b1;
    k = 0;
    while (!in_ready && k < 50) begin
      @(posedge clk); #1; k++;
    end
    ok = in_ready;
    if (ok) sb.push_back(model(ai, bi, bini));
    @(posedge clk); #1;
    in_valid = 1'b0;
    a = $urandom; b = $urandom; bin = 1'($urandom);
  endtask

  task automatic wait_done(output int lat);
    lat = 0;
    while (!out_valid && lat < 100) begin
      @(posedge clk); #1; lat++;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; a = '0; b = '0; bin = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    n_checks++;
    if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready: got %b expected 1", in_ready); end
    n_checks++;
    if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
    n_checks++;
    if (diff !== 32'h0) begin n_fail++; $display("FAIL reset_diff: got %h expected 0", diff); end
    n_checks++;
    if (bout !== 1'b0) begin n_fail++; $display("FAIL reset_bout: got %b expected 0", bout); end
`ifdef SUB32_OVF_EN
    n_checks++;
    if (ovf !== 1'b0) begin n_fail++; $display("FAIL reset_ovf: got %b expected 0", ovf); end
`endif
  endtask

  task automatic test_arith();
    vec_t vecs[$];
    bit   ok;
    int   lat;
    exp_t e;
    vecs.push_back('{32'h0000_0001, 32'h0000_0000, 1'b0});
    vecs.push_back('{32'h0000_0000, 32'h0000_0001, 1'b0});
    vecs.push_back('{32'h0000_0000, 32'h0000_0000, 1'b1});
    vecs.push_back('{32'h1234_5678, 32'h1234_5678, 1'b0});
    vecs.push_back('{32'h8000_0000, 32'h0000_0001, 1'b0});
    vecs.push_back('{32'h0000_0005, 32'h0000_0003, 1'b0});
    vecs.push_back('{32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1});
    vecs.push_back('{32'h7FFF_FFFF, 32'hFFFF_FFFF, 1'b0});
    for (int i = 0; i < 8; i++) vecs.push_back('{32'($urandom), 32'($urandom), 1'($urandom)});
    foreach (vecs[i]) begin
      start_op(vecs[i].va, vecs[i].vb, vecs[i].vbin, ok);
      n_checks++;
      if (!ok) begin n_fail++; $display("FAIL arith_accept[%0d]: in_ready never rose", i); continue; end
      wait_done(lat);
      n_checks++;
      if (lat != 9) begin n_fail++; $display("FAIL arith_latency[%0d]: got %0d expected 9", i, lat); end
      e = sb.pop_front();
      n_checks++;
      if (diff !== e.d) begin n_fail++; $display("FAIL arith_diff[%0d]: got %h expected %h", i, diff, e.d); end
      n_checks++;
      if (bout !== e.bo) begin n_fail++; $display("FAIL arith_bout[%0d]: got %b expected %b", i, bout, e.bo); end
`ifdef SUB32_OVF_EN
      n_checks++;
      if (ovf !== e.ov) begin n_fail++; $display("FAIL arith_ovf[%0d]: got %b expected %b", i, ovf, e.ov); end
`endif
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
      n_checks++;
      if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
        n_fail++;
        $display("FAIL arith_release[%0d]: got in_ready=%b out_valid=%b expected 1/0", i, in_ready, out_valid);
      end
    end
  endtask

  task automatic test_backpressure();
    bit          ok;
    int          lat, seen;
    exp_t        e;
    logic [31:0] d0;
    logic        b0;
    start_op(32'h0BAD_F00D, 32'h1234_ABCD, 1'b1, ok);
    wait_done(lat);
    n_checks++;
    if (!ok || lat != 9) begin n_fail++; $display("FAIL bp_latency: got %0d expected 9", lat); end
    d0 = diff; b0 = bout;
    for (int c = 0; c < 5; c++) begin
      if (c == 2) begin a = 32'h1; b = 32'h2; bin = 1'b0; in_valid = 1'b1; end
      else in_valid = 1'b0;
      @(posedge clk); #1;
      n_checks++;
      if (out_valid !== 1'b1 || in_ready !== 1'b0 || diff !== d0 || bout !== b0) begin
        n_fail++;
        $display("FAIL bp_hold[%0d]: got out_valid=%b in_ready=%b diff=%h expected 1/0/%h", c, out_valid, in_ready, diff, d0);
      end
    end
    in_valid = 1'b0;
    e = sb.pop_front();
    n_checks++;
    if (d0 !== e.d || b0 !== e.bo) begin n_fail++; $display("FAIL bp_result: got %h/%b expected %h/%b", d0, b0, e.d, e.bo); end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    seen = 0;
    for (int c = 0; c < 12; c++) begin
      if (out_valid) seen++;
      @(posedge clk); #1;
    end
    n_checks++;
    if (seen != 0) begin n_fail++; $display("FAIL bp_ignored_req: got %0d out_valid cycles expected 0", seen); end
  endtask

  task automatic test_back_to_back();
    bit   ok;
    int   lat;
    exp_t e;
    start_op(32'hDEAD_BEEF, 32'hCAFE_F00D, 1'b0, ok);
    wait_done(lat);
    e = sb.pop_front();
    n_checks++;
    if (!ok || diff !== e.d || bout !== e.bo) begin n_fail++; $display("FAIL b2b_first: got %h/%b expected %h/%b", diff, bout, e.d, e.bo); end
    a = 32'h0000_0010; b = 32'h0000_0020; bin = 1'b1;
    out_ready = 1'b1; in_valid = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    n_checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL b2b_not_taken: got in_ready=%b out_valid=%b expected 1/0", in_ready, out_valid);
    end
    sb.push_back(model(32'h0000_0010, 32'h0000_0020, 1'b1));
    @(posedge clk); #1;
    in_valid = 1'b0; a = '0; b = '0; bin = 1'b0;
    n_checks++;
    if (in_ready !== 1'b0) begin n_fail++; $display("FAIL b2b_accept: got in_ready=%b expected 0", in_ready); end
    wait_done(lat);
    n_checks++;
    if (lat != 9) begin n_fail++; $display("FAIL b2b_latency: got %0d expected 9", lat); end
    e = sb.pop_front();
    n_checks++;
    if (diff !== e.d || bout !== e.bo) begin n_fail++; $display("FAIL b2b_second: got %h/%b expected %h/%b", diff, bout, e.d, e.bo); end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic test_reset_mid_run();
    bit   ok;
    int   lat, seen;
    exp_t e;
    a = 32'h5555_AAAA; b = 32'h1111_2222; bin = 1'b0; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (3) begin @(posedge clk); #1; end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    n_checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || diff !== 32'h0 || bout !== 1'b0) begin
      n_fail++;
      $display("FAIL rst_mid_run: got in_ready=%b out_valid=%b diff=%h bout=%b expected 1/0/0/0", in_ready, out_valid, diff, bout);
    end
    seen = 0;
    for (int c = 0; c < 12; c++) begin
      if (out_valid) seen++;
      @(posedge clk); #1;
    end
    n_checks++;
    if (seen != 0) begin n_fail++; $display("FAIL rst_no_result: got %0d out_valid cycles expected 0", seen); end
    start_op(32'h0000_0100, 32'h0000_0001, 1'b1, ok);
    wait_done(lat);
    n_checks++;
    if (!ok || lat != 9) begin n_fail++; $display("FAIL rst_recover_latency: got %0d expected 9", lat); end
    e = sb.pop_front();
    n_checks++;
    if (diff !== e.d || bout !== e.bo) begin n_fail++; $display("FAIL rst_recover: got %h/%b expected %h/%b", diff, bout, e.d, e.bo); end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  initial begin
    test_reset();
    test_arith();
    test_backpressure();
    test_back_to_back();
    test_reset_mid_run();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
